// File: rtl/atconv_pkg.sv
// Shared constants and types for the atrous-conv layer-memory arbiter.
package atconv_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 13;

  localparam int L0_SIZE = 4096;
  localparam int L1_SIZE = 1024;

  localparam int REQ_CONV    = 0;
  localparam int REQ_POOL_RD = 1;
  localparam int REQ_POOL_WR = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/atconv_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module atconv_rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int          j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/atconv_mem_arb.sv
// Round-robin arbiter sharing one layer-memory port among NREQ engines, with burst lock.
// Build option ATCONV_ARB_FIXED_PRIO_EN: requester 0 always wins and pre-empts bursts.
module atconv_mem_arb
  import atconv_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ-1:0]        sel,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   cwr,
  output logic [ADDR_W-1:0]      caddr_wr,
  output logic [DATA_W-1:0]      cdata_wr,
  output logic                   crd,
  output logic [ADDR_W-1:0]      caddr_rd,
  input  logic [DATA_W-1:0]      cdata_rd,
  output logic                   csel,
  output logic                   busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt, ptr, ptr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] arb_req, pick_gnt, gnt_int, owner_oh;
  logic [IW-1:0]   pick_idx, win, rd_id;
  logic            pick_any, win_any, preempt, own_hold;

  assign owner_oh = NREQ'(1) << owner;

`ifdef ATCONV_ARB_FIXED_PRIO_EN
  assign arb_req = req[REQ_CONV] ? (NREQ'(1) << REQ_CONV) : req;
  assign preempt = (state == ARB_OWN) && (owner != IW'(REQ_CONV)) && req[REQ_CONV];
`else
  assign arb_req = req;
  assign preempt = 1'b0;
`endif

  assign own_hold = (state == ARB_OWN) && req[owner] && !preempt;

  atconv_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (arb_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // cnt holds beats already granted in the current ownership window
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_int   = '0;
    win       = owner;
    win_any   = 1'b0;
    if (own_hold) begin
      gnt_int = owner_oh;
      win_any = 1'b1;
      if (!lock[owner]) begin
        state_nxt = ARB_IDLE;
        cnt_nxt   = '0;
      end else if (cnt == CW'(MAX_BURST - 1)) begin
        cnt_nxt = '0;
        if (|(req & ~owner_oh)) state_nxt = ARB_IDLE;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else begin
      state_nxt = ARB_IDLE;
      cnt_nxt   = '0;
      if (pick_any) begin
        gnt_int = pick_gnt;
        win     = pick_idx;
        win_any = 1'b1;
        ptr_nxt = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        if (lock[pick_idx]) begin
          state_nxt = ARB_OWN;
          owner_nxt = pick_idx;
          cnt_nxt   = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Memory side is registered; read data comes back one cycle after crd
  always_ff @(posedge clk) begin
    if (reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      caddr_rd <= '0;
      rd_id    <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      cwr <= win_any & we[win];
      crd <= win_any & ~we[win];
      if (win_any) begin
        csel  <= sel[win];
        rd_id <= win;
        if (we[win]) begin
          caddr_wr <= addr[win*ADDR_W +: ADDR_W];
          cdata_wr <= wdata[win*DATA_W +: DATA_W];
        end else begin
          caddr_rd <= addr[win*ADDR_W +: ADDR_W];
        end
      end
      rvalid <= crd ? (NREQ'(1) << rd_id) : '0;
      if (crd) rdata <= cdata_rd;
    end
  end

  assign gnt  = reset ? '0 : gnt_int;
  assign busy = (|gnt) | cwr | crd | (|rvalid);

endmodule

// File: tb/tb_atconv_mem_arb.sv
// Directed scoreboard bench for atconv_mem_arb; expected memory commands and read returns are queued.
module tb_atconv_mem_arb;

  localparam int NREQ = 3;
  localparam int AW   = 13;
  localparam int DW   = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, lock, we, sel;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              cwr, crd, csel, busy;
  logic [AW-1:0]     caddr_wr, caddr_rd;
  logic [DW-1:0]     cdata_wr, cdata_rd;

  typedef struct {
    logic          we;
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            id;
  } cmd_t;

  cmd_t cmd_q[$];
  cmd_t rd_q[$];

  int checks   = 0;
  int failures = 0;

  int   seq_exp[$];
  int   rem[NREQ];
  int   start_at[NREQ];
  logic lk[NREQ];
  int   base[NREQ] = '{100, 300, 500};
  logic [NREQ-1:0] we_cfg  = 3'b101;
  logic [NREQ-1:0] sel_cfg = 3'b100;

  atconv_mem_arb dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .we       (we),
    .sel      (sel),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
    return a ^ {a[5:0], 7'b0};
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic setReq(input int i, input logic w, input logic s, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic l);
    req[i]            = 1'b1;
    we[i]             = w;
    sel[i]            = s;
    lock[i]           = l;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic doReset(input string tag);
    req   = '0;
    lock  = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    checkVal({tag, "_gnt"},      32'(gnt),      0);
    checkVal({tag, "_rvalid"},   32'(rvalid),   0);
    checkVal({tag, "_rdata"},    32'(rdata),    0);
    checkVal({tag, "_cwr"},      32'(cwr),      0);
    checkVal({tag, "_crd"},      32'(crd),      0);
    checkVal({tag, "_csel"},     32'(csel),     0);
    checkVal({tag, "_caddr_wr"}, 32'(caddr_wr), 0);
    checkVal({tag, "_cdata_wr"}, 32'(cdata_wr), 0);
    checkVal({tag, "_caddr_rd"}, 32'(caddr_rd), 0);
    checkVal({tag, "_busy"},     32'(busy),     0);
    reset = 1'b0;
    cmd_q.delete();
    rd_q.delete();
  endtask

  // Called just after a rising edge: compare read returns and memory commands against the queues
  task automatic checkOutput(input string tag);
    cmd_t c;
    if (rd_q.size() > 0) begin
      c = rd_q.pop_front();
      checkVal({tag, "_rvalid"}, 32'(rvalid), 32'(NREQ'(1) << c.id));
      checkVal({tag, "_rdata"},  32'(rdata),  32'(c.data));
    end else begin
      checkVal({tag, "_rvalid_idle"}, 32'(rvalid), 0);
    end
    if (cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      checkVal({tag, "_cwr"},  32'(cwr),  32'(c.we));
      checkVal({tag, "_crd"},  32'(crd),  32'(!c.we));
      checkVal({tag, "_csel"}, 32'(csel), 32'(c.sel));
      if (c.we) begin
        checkVal({tag, "_caddr_wr"}, 32'(caddr_wr), 32'(c.addr));
        checkVal({tag, "_cdata_wr"}, 32'(cdata_wr), 32'(c.data));
      end else begin
        checkVal({tag, "_caddr_rd"}, 32'(caddr_rd), 32'(c.addr));
        cdata_rd = memModel(c.addr);
        c.data   = memModel(c.addr);
        rd_q.push_back(c);
      end
    end else begin
      checkVal({tag, "_cmd_idle"}, 32'({cwr, crd}), 0);
    end
  endtask

  task automatic stepCycle(input logic [NREQ-1:0] exp_gnt, input string tag);
    cmd_t c;
    #1;
    checkVal({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    if (exp_gnt != '0) begin
      checkVal({tag, "_busy"}, 32'(busy), 1);
      for (int i = 0; i < NREQ; i++) begin
        if (exp_gnt[i]) begin
          c.we   = we[i];
          c.sel  = sel[i];
          c.addr = addr[i*AW +: AW];
          c.data = wdata[i*DW +: DW];
          c.id   = i;
          cmd_q.push_back(c);
        end
      end
    end
    @(posedge clk); #1;
    checkOutput(tag);
  endtask

  // Runs seq_exp against requesters configured by rem/start_at/lk; each drops req after its beats
  task automatic applyStimulus(input string tag);
    int beat[NREQ];
    int v;
    logic [NREQ-1:0] e;
    for (int i = 0; i < NREQ; i++) beat[i] = 0;
    for (int k = 0; k < seq_exp.size(); k++) begin
      for (int i = 0; i < NREQ; i++) begin
        req[i]            = (k >= start_at[i]) && (rem[i] > 0);
        lock[i]           = lk[i];
        we[i]             = we_cfg[i];
        sel[i]            = sel_cfg[i];
        addr[i*AW +: AW]  = AW'(base[i] + beat[i]);
        wdata[i*DW +: DW] = DW'(i * 1000 + beat[i]);
      end
      v = seq_exp[k];
      e = (v < 0) ? '0 : (NREQ'(1) << v);
      stepCycle(e, $sformatf("%s_s%0d", tag, k));
      if (v >= 0) begin
        rem[v]--;
        beat[v]++;
      end
    end
    req  = '0;
    lock = '0;
    stepCycle('0, {tag, "_drain0"});
    stepCycle('0, {tag, "_drain1"});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    req      = '0;
    lock     = '0;
    we       = '0;
    sel      = '0;
    addr     = '0;
    wdata    = '0;
    cdata_rd = '0;

    doReset("rst0");

    $display("[TB] single write");
    setReq(0, 1'b1, 1'b0, 13'd5, 13'h0123, 1'b0);
    stepCycle(3'b001, "t1");
    req = '0;
    stepCycle(3'b000, "t1_idle");
    checkVal("t1_busy_idle", 32'(busy), 0);

    $display("[TB] single read");
    setReq(1, 1'b0, 1'b0, 13'd64, 13'h0, 1'b0);
    stepCycle(3'b010, "t2");
    req = '0;
    stepCycle(3'b000, "t2_ret");
    checkVal("t2_rdata_0040", 32'(rdata), 32'h0040);
    stepCycle(3'b000, "t2_idle");

    $display("[TB] three-way round robin");
    doReset("rst3");
    rem      = '{2, 2, 2};
    start_at = '{0, 0, 0};
    lk       = '{1'b0, 1'b0, 1'b0};
`ifdef ATCONV_ARB_FIXED_PRIO_EN
    seq_exp  = '{0, 0, 1, 2, 1, 2};
`else
    seq_exp  = '{0, 1, 2, 0, 1, 2};
`endif
    applyStimulus("t3");

    $display("[TB] locked burst with competitor");
    doReset("rst4a");
    rem      = '{20, 1, 0};
    start_at = '{0, 1, 0};
    lk       = '{1'b1, 1'b0, 1'b0};
    seq_exp.delete();
`ifdef ATCONV_ARB_FIXED_PRIO_EN
    repeat (20) seq_exp.push_back(0);
    seq_exp.push_back(1);
`else
    repeat (16) seq_exp.push_back(0);
    seq_exp.push_back(1);
    repeat (4) seq_exp.push_back(0);
`endif
    applyStimulus("t4a");

    $display("[TB] locked burst alone");
    doReset("rst4b");
    rem      = '{20, 0, 0};
    start_at = '{0, 0, 0};
    lk       = '{1'b1, 1'b0, 1'b0};
    seq_exp.delete();
    repeat (20) seq_exp.push_back(0);
    applyStimulus("t4b");

    $display("[TB] reset during read");
    doReset("rst5");
    setReq(1, 1'b0, 1'b1, 13'd64, 13'h0, 1'b0);
    stepCycle(3'b010, "t5_grant");
    req   = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    checkVal("t5_crd",    32'(crd),    0);
    checkVal("t5_rvalid", 32'(rvalid), 0);
    checkVal("t5_busy",   32'(busy),   0);
    checkVal("t5_cwr",    32'(cwr),    0);
    reset = 1'b0;
    cmd_q.delete();
    rd_q.delete();
    stepCycle(3'b000, "t5_after");

    $display("[TB] requester 0 arriving during locked burst");
    doReset("rst6");
    rem      = '{1, 5, 0};
    start_at = '{3, 0, 0};
    lk       = '{1'b0, 1'b1, 1'b0};
`ifdef ATCONV_ARB_FIXED_PRIO_EN
    seq_exp  = '{1, 1, 1, 0, 1, 1};
`else
    seq_exp  = '{1, 1, 1, 1, 1, 0};
`endif
    applyStimulus("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
